// File: rtl/hv_ramp_pkg.sv
// hv_ramp_pkg: state encodings, default timing constants and the step helper for the HV ramp sequencer
package hv_ramp_pkg;
    localparam int TICK_W = 24;
    localparam int DEF_PRESC_DIV = 256;
    localparam int DEF_SETTLE_TICKS = 194;
    localparam int DEF_DWELL_TICKS = 86805;
    localparam int DEF_STEP = 228;
    localparam int DEF_MAX_CODE = 2310;

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_RAMP_UP, S_HOLD, S_RAMP_DOWN, S_SHUTDOWN, S_ABORT
    } state_e;

    localparam logic [2:0] ST_IDLE = S_IDLE;
    localparam logic [2:0] ST_SETTLE = S_SETTLE;
    localparam logic [2:0] ST_RAMP_UP = S_RAMP_UP;
    localparam logic [2:0] ST_HOLD = S_HOLD;
    localparam logic [2:0] ST_RAMP_DOWN = S_RAMP_DOWN;
    localparam logic [2:0] ST_SHUTDOWN = S_SHUTDOWN;
    localparam logic [2:0] ST_ABORT = S_ABORT;

    // One step from w toward goal g, saturating at g in either direction; up path is 13-bit so it cannot wrap
    function automatic logic [11:0] step_to(input logic [11:0] w, input logic [11:0] g, input logic [11:0] step);
        logic [12:0] up;
        logic [11:0] dn;
        up = {1'b0, w} + {1'b0, step};
        dn = (w > step) ? w - step : 12'd0;
        return (g > w) ? ((up > {1'b0, g}) ? g : up[11:0]) : ((dn < g) ? g : dn);
    endfunction
endpackage

// File: rtl/hv_tick_timer.sv
// hv_tick_timer: clk50 prescaler plus loadable tick down-counter; done marks the cycle the count expires and after
module hv_tick_timer import hv_ramp_pkg::*; #(
    parameter int PRESC_DIV = DEF_PRESC_DIV
) (
    input  logic              clk50,
    input  logic              rst_n,
    input  logic              load,
    input  logic [TICK_W-1:0] ticks,
    output logic              done
);
    localparam int PW = $clog2(PRESC_DIV + 1);
    localparam logic [PW-1:0] P_LAST = PW'(PRESC_DIV - 1);
    logic [PW-1:0] presc;
    logic [TICK_W-1:0] cnt;
    logic tick;
    assign tick = presc == P_LAST;
    // Asserting done on the final tick lets the consumer act exactly ticks*PRESC_DIV cycles after load
    assign done = (cnt == '0) || (cnt == TICK_W'(1) && tick);
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            cnt <= '0;
        end else if (load) begin
            presc <= '0;
            cnt <= ticks;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick && cnt != '0) cnt <= cnt - TICK_W'(1);
        end
    end
endmodule

// File: rtl/hv_ramp_sequencer.sv
// hv_ramp_sequencer: step-and-dwell MCP HVPS DAC ramp with settle, retarget, controlled shutdown and abort
module hv_ramp_sequencer import hv_ramp_pkg::*; #(
    parameter int PRESC_DIV = DEF_PRESC_DIV,
    parameter int SETTLE_TICKS = DEF_SETTLE_TICKS,
    parameter int DWELL_TICKS = DEF_DWELL_TICKS,
    parameter int STEP = DEF_STEP,
    parameter int MAX_CODE = DEF_MAX_CODE
) (
    input  logic        clk50,
    input  logic        rst_n,
    input  logic        hven_cmd,
    input  logic        safe_cmd,
    input  logic        reset_cmd,
    input  logic [11:0] target,
    input  logic        dac_busy,
    output logic        dac_load,
    output logic [11:0] dac_word,
    output logic        hven,
    output logic        at_target,
    output logic [2:0]  ramp_state
);
    localparam logic [11:0] MAX_C = 12'(MAX_CODE);
    localparam logic [11:0] STEP_C = 12'(STEP);
    logic [2:0] state, state_n;
    logic [11:0] tgt, word_n;
    logic load_n, hven_n, pend, pend_n, settle_ld, done;

    assign tgt = (target > MAX_C) ? MAX_C : target;
    assign ramp_state = state;
    assign at_target = (state == ST_HOLD) && (dac_word == tgt);

    hv_tick_timer #(.PRESC_DIV(PRESC_DIV)) u_timer (
        .clk50(clk50),
        .rst_n(rst_n),
        .load(load_n || settle_ld),
        .ticks(settle_ld ? TICK_W'(SETTLE_TICKS) : TICK_W'(DWELL_TICKS)),
        .done(done)
    );

    always_comb begin
        state_n = state;
        word_n = dac_word;
        load_n = 1'b0;
        hven_n = hven;
        pend_n = pend;
        settle_ld = 1'b0;
        if (reset_cmd && state != ST_IDLE && state != ST_ABORT) begin
            state_n = ST_ABORT;
            word_n = 12'd0;
            load_n = !dac_busy;
            pend_n = dac_busy;
            hven_n = 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (hven_cmd && !safe_cmd && !reset_cmd) begin
                    state_n = ST_SETTLE;
                    hven_n = 1'b1;
                    settle_ld = 1'b1;
                end
                ST_SETTLE, ST_RAMP_UP, ST_HOLD, ST_RAMP_DOWN: begin
                    if (safe_cmd || !hven_cmd) state_n = ST_SHUTDOWN;
                    else if (state != ST_SETTLE || done) begin
                        // A due step stays pending while busy because done holds until the next load
                        load_n = done && !dac_busy && dac_word != tgt;
                        word_n = load_n ? step_to(dac_word, tgt, STEP_C) : dac_word;
                        state_n = (word_n == tgt) ? ST_HOLD : (word_n < tgt) ? ST_RAMP_UP : ST_RAMP_DOWN;
                    end
                end
                ST_SHUTDOWN: begin
                    if (dac_word == 12'd0) begin
                        if (!dac_busy && !dac_load) begin
                            state_n = ST_IDLE;
                            hven_n = 1'b0;
                        end
                    end else begin
                        load_n = done && !dac_busy;
                        word_n = load_n ? step_to(dac_word, 12'd0, STEP_C) : dac_word;
                    end
                end
                ST_ABORT: begin
                    load_n = pend && !dac_busy;
                    pend_n = pend && dac_busy;
                    if (!pend && !reset_cmd) state_n = ST_IDLE;
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            dac_word <= 12'd0;
            dac_load <= 1'b0;
            hven <= 1'b0;
            pend <= 1'b0;
        end else begin
            state <= state_n;
            dac_word <= word_n;
            dac_load <= load_n;
            hven <= hven_n;
            pend <= pend_n;
        end
    end
endmodule

// File: tb/tb_hv_ramp_sequencer.sv
// tb_hv_ramp_sequencer: directed scenarios with a load scoreboard checking DAC codes and their exact cycles
module tb_hv_ramp_sequencer;
    import hv_ramp_pkg::*;

    typedef struct {
        logic [11:0] w;
        int at;
    } load_t;

    logic clk50 = 1'b0;
    logic rst_n = 1'b0;
    logic hven_cmd = 1'b0;
    logic safe_cmd = 1'b0;
    logic reset_cmd = 1'b0;
    logic [11:0] target = 12'd0;
    logic dac_busy = 1'b0;
    logic dac_load, hven, at_target;
    logic [11:0] dac_word;
    logic [2:0] ramp_state;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    load_t exp_q[$];

    hv_ramp_sequencer #(
        .PRESC_DIV(4), .SETTLE_TICKS(2), .DWELL_TICKS(4), .STEP(100), .MAX_CODE(500)
    ) dut (
        .clk50(clk50), .rst_n(rst_n), .hven_cmd(hven_cmd), .safe_cmd(safe_cmd),
        .reset_cmd(reset_cmd), .target(target), .dac_busy(dac_busy), .dac_load(dac_load),
        .dac_word(dac_word), .hven(hven), .at_target(at_target), .ramp_state(ramp_state)
    );

    always #10 clk50 = ~clk50;
    always @(posedge clk50) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int w, input int at);
        load_t e;
        e.w = 12'(w);
        e.at = at;
        exp_q.push_back(e);
    endtask

    task automatic at_cyc(input int t);
        while (cyc < t) @(negedge clk50);
    endtask

    // Monitor: every observed load must match the head of the expected queue in code and cycle
    initial begin
        load_t e;
        forever begin
            @(negedge clk50);
            if (rst_n && dac_load) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_load: got word %0d at cycle %0d, expected no load", dac_word, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("load_word", int'(dac_word), int'(e.w));
                    chk("load_cycle", cyc, e.at);
                end
            end
        end
    end

    initial begin
        int h, s, c;
        repeat (3) @(negedge clk50);
        rst_n = 1'b1;
        @(negedge clk50);
        chk("rst_load", int'(dac_load), 0);
        chk("rst_word", int'(dac_word), 0);
        chk("rst_hven", int'(hven), 0);
        chk("rst_at_target", int'(at_target), 0);
        chk("rst_state", int'(ramp_state), int'(ST_IDLE));

        // Ramp up to 350
        target = 12'd350;
        hven_cmd = 1'b1;
        h = cyc + 1;
        push(100, h + 8); push(200, h + 24); push(300, h + 40); push(350, h + 56);
        at_cyc(h);
        chk("t1_hven", int'(hven), 1);
        chk("t1_settle", int'(ramp_state), int'(ST_SETTLE));
        chk("t1_at_target_early", int'(at_target), 0);
        at_cyc(h + 76);
        chk("t1_hold", int'(ramp_state), int'(ST_HOLD));
        chk("t1_word", int'(dac_word), 350);
        chk("t1_at_target", int'(at_target), 1);

        // Safe in HOLD: controlled ramp-down to zero
        safe_cmd = 1'b1;
        s = cyc + 1;
        push(250, s + 1); push(150, s + 17); push(50, s + 33); push(0, s + 49);
        at_cyc(s);
        chk("t4_shutdown", int'(ramp_state), int'(ST_SHUTDOWN));
        at_cyc(s + 49);
        chk("t4_hven_at_last_load", int'(hven), 1);
        at_cyc(s + 55);
        chk("t4_idle", int'(ramp_state), int'(ST_IDLE));
        chk("t4_hven_off", int'(hven), 0);
        safe_cmd = 1'b0;
        hven_cmd = 1'b0;
        at_cyc(cyc + 5);

        // Reset mid-ramp with a coincident safe_cmd
        hven_cmd = 1'b1;
        h = cyc + 1;
        push(100, h + 8); push(200, h + 24);
        at_cyc(h + 25);
        reset_cmd = 1'b1;
        safe_cmd = 1'b1;
        push(0, h + 26);
        at_cyc(h + 26);
        chk("t5_hven", int'(hven), 0);
        chk("t5_abort", int'(ramp_state), int'(ST_ABORT));
        chk("t5_word", int'(dac_word), 0);
        at_cyc(h + 29);
        chk("t5_abort_held", int'(ramp_state), int'(ST_ABORT));
        reset_cmd = 1'b0;
        safe_cmd = 1'b0;
        hven_cmd = 1'b0;
        at_cyc(h + 30);
        chk("t5_idle", int'(ramp_state), int'(ST_IDLE));
        at_cyc(h + 35);

        // Clamp at MAX_CODE
        target = 12'd4095;
        hven_cmd = 1'b1;
        h = cyc + 1;
        push(100, h + 8); push(200, h + 24); push(300, h + 40); push(400, h + 56); push(500, h + 72);
        at_cyc(h + 92);
        chk("t2_hold", int'(ramp_state), int'(ST_HOLD));
        chk("t2_word", int'(dac_word), 500);
        chk("t2_at_target", int'(at_target), 1);

        // Retarget down from 500 to 180
        target = 12'd180;
        c = cyc;
        push(400, c + 1); push(300, c + 17); push(200, c + 33); push(180, c + 49);
        at_cyc(c + 1);
        chk("t6_ramp_down", int'(ramp_state), int'(ST_RAMP_DOWN));
        at_cyc(c + 69);
        chk("t6_hold", int'(ramp_state), int'(ST_HOLD));
        chk("t6_word", int'(dac_word), 180);
        chk("t6_at_target", int'(at_target), 1);
        chk("t6_hven", int'(hven), 1);

        // Busy back-pressure over a due step
        target = 12'd500;
        c = cyc;
        push(280, c + 1); push(380, c + 36); push(480, c + 52); push(500, c + 68);
        at_cyc(c + 5);
        dac_busy = 1'b1;
        at_cyc(c + 35);
        dac_busy = 1'b0;
        at_cyc(c + 88);
        chk("t3_hold", int'(ramp_state), int'(ST_HOLD));
        chk("t3_word", int'(dac_word), 500);

        // Asynchronous reset mid-transfer
        target = 12'd0;
        c = cyc;
        push(400, c + 1);
        at_cyc(c + 3);
        hven_cmd = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_word", int'(dac_word), 0);
        chk("arst_hven", int'(hven), 0);
        chk("arst_load", int'(dac_load), 0);
        chk("arst_state", int'(ramp_state), int'(ST_IDLE));
        repeat (3) @(negedge clk50);
        rst_n = 1'b1;
        repeat (10) @(negedge clk50);
        chk("end_state", int'(ramp_state), int'(ST_IDLE));
        chk("pending_loads", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
